// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencer for the 5-stage RISC-V pipeline
// Arbitrates memory wait, MDU, branch redirect and load-use requests onto stage enables/flushes.
module pipeline_stall_ctrl #(
   parameter int MDU_LATENCY = 4,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_use_req,
   input  logic             branch_taken,
   input  logic             mdu_start,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             EXMEMWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             EXMEMFlush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       state_o
);

   localparam int MW = $clog2(MEM_TIMEOUT + 1);
   localparam int DW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
   localparam logic [MW-1:0] MEM_TO   = MW'(MEM_TIMEOUT);
   localparam logic [DW-1:0] MDU_INIT = DW'(MDU_LATENCY - 2);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      MDU_WAIT = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [MW-1:0] mem_cnt, mem_cnt_n;
   logic [DW-1:0] mdu_cnt, mdu_cnt_n;
   logic          decode_en, mem_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mem_cnt     <= '0;
         mdu_cnt     <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
      end else begin
         state   <= state_n;
         mem_cnt <= mem_cnt_n;
         mdu_cnt <= mdu_cnt_n;
         if (state_n == MEM_WAIT && mem_cnt_n == MEM_TO)
            mem_timeout <= 1'b1;
         if (!PCWrite && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end

   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXWrite  = 1'b1;
      EXMEMWrite = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXFlush  = 1'b0;
      EXMEMFlush = 1'b0;
      state_n    = state;
      mem_cnt_n  = mem_cnt;
      mdu_cnt_n  = mdu_cnt;
      decode_en  = 1'b0;
      mem_en     = 1'b0;

      if (rst) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMWrite = 1'b0;
         IFIDFlush  = 1'b1;
         IDEXFlush  = 1'b1;
         EXMEMFlush = 1'b1;
         state_n    = IDLE;
         mem_cnt_n  = '0;
         mdu_cnt_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               decode_en = 1'b1;
               mem_en    = 1'b1;
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXWrite  = 1'b0;
                  EXMEMWrite = 1'b0;
                  if (mem_cnt < MEM_TO)
                     mem_cnt_n = mem_cnt + 1'b1;
               end else begin
                  decode_en = 1'b1;
                  state_n   = IDLE;
               end
            end
            MDU_WAIT: begin
               if (mdu_cnt != '0) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXWrite  = 1'b0;
                  EXMEMFlush = 1'b1;
                  mdu_cnt_n  = mdu_cnt - 1'b1;
               end else begin
                  decode_en = 1'b1;
                  mem_en    = 1'b1;
                  state_n   = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase

         // Priority decode; mdu_start beats branch_taken so the branch re-presents after release
         if (decode_en) begin
            if (mem_en && mem_req && !mem_ready) begin
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               IDEXWrite  = 1'b0;
               EXMEMWrite = 1'b0;
               state_n    = MEM_WAIT;
               mem_cnt_n  = MW'(1);
            end else if (mdu_start) begin
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               IDEXWrite  = 1'b0;
               EXMEMFlush = 1'b1;
               state_n    = MDU_WAIT;
               mdu_cnt_n  = MDU_INIT;
            end else if (branch_taken) begin
               IFIDFlush = 1'b1;
               IDEXFlush = 1'b1;
            end else if (load_use_req) begin
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               IDEXFlush = 1'b1;
            end
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst, load_use_req, branch_taken, mdu_start, mem_req, mem_ready;
   logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
   logic        IFIDFlush, IDEXFlush, EXMEMFlush, mem_timeout;
   logic [15:0] stall_count;
   logic [1:0]  state_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [6:0] ctrl;
      logic [1:0] st;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [6:0] DEF   = 7'b1111_000;
   localparam logic [6:0] RSTV  = 7'b0000_111;
   localparam logic [6:0] MEMST = 7'b0000_000;
   localparam logic [6:0] MDUST = 7'b0001_001;
   localparam logic [6:0] BR    = 7'b1111_110;
   localparam logic [6:0] LU    = 7'b0011_010;

   pipeline_stall_ctrl #(.MDU_LATENCY(4), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .load_use_req(load_use_req), .branch_taken(branch_taken),
      .mdu_start(mdu_start), .mem_req(mem_req), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
      .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
      .mem_timeout(mem_timeout), .stall_count(stall_count), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, queue the expected outputs, compare at the falling edge
   task automatic step(input string tag, input logic r, input logic lu, input logic br,
                       input logic md, input logic mq, input logic mr,
                       input logic [6:0] ctrl, input logic [1:0] st);
      exp_t e;
      rst = r; load_use_req = lu; branch_taken = br;
      mdu_start = md; mem_req = mq; mem_ready = mr;
      exp_q.push_back('{ctrl: ctrl, st: st});
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_ctrl"}, {25'd0, PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                             IFIDFlush, IDEXFlush, EXMEMFlush}, {25'd0, e.ctrl});
      check({tag, "_state"}, {30'd0, state_o}, {30'd0, e.st});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; load_use_req = 0; branch_taken = 0; mdu_start = 0; mem_req = 0; mem_ready = 0;

      step("rst0", 1, 0, 0, 0, 0, 0, RSTV, 2'd0);
      step("rst1", 1, 0, 0, 0, 0, 0, RSTV, 2'd0);
      step("idle", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("cnt_reset", {16'd0, stall_count}, 32'd0);

      step("lu", 0, 1, 0, 0, 0, 0, LU, 2'd0);
      step("lu_after", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("cnt_lu", {16'd0, stall_count}, 32'd1);

      step("mdu_issue", 0, 0, 0, 1, 0, 0, MDUST, 2'd0);
      step("mdu_w1", 0, 0, 0, 0, 0, 0, MDUST, 2'd2);
      step("mdu_w2", 0, 0, 0, 0, 0, 0, MDUST, 2'd2);
      step("mdu_rel", 0, 0, 0, 0, 0, 0, DEF, 2'd2);
      step("mdu_idle", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("cnt_mdu", {16'd0, stall_count}, 32'd4);

      step("mem_w0", 0, 0, 1, 0, 1, 0, MEMST, 2'd0);
      step("mem_w1", 0, 0, 1, 0, 1, 0, MEMST, 2'd1);
      step("mem_w2", 0, 0, 1, 0, 1, 0, MEMST, 2'd1);
      step("mem_rdy_br", 0, 0, 1, 0, 1, 1, BR, 2'd1);
      step("mem_idle", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("cnt_mem", {16'd0, stall_count}, 32'd7);

      step("mdubr_issue", 0, 0, 1, 1, 0, 0, MDUST, 2'd0);
      step("mdubr_w1", 0, 0, 1, 0, 0, 0, MDUST, 2'd2);
      step("mdubr_w2", 0, 0, 1, 0, 0, 0, MDUST, 2'd2);
      step("mdubr_rel", 0, 0, 1, 0, 0, 0, BR, 2'd2);
      step("mdubr_idle", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("cnt_mdubr", {16'd0, stall_count}, 32'd10);

      step("to_w0", 0, 0, 0, 0, 1, 0, MEMST, 2'd0);
      for (int i = 1; i < 20; i++) begin
         step("to_w", 0, 0, 0, 0, 1, 0, MEMST, 2'd1);
         if (i == 10) check("timeout_early", {31'd0, mem_timeout}, 32'd0);
      end
      check("timeout_set", {31'd0, mem_timeout}, 32'd1);
      step("to_rdy", 0, 0, 0, 0, 1, 1, DEF, 2'd1);
      step("to_idle", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
      check("cnt_to", {16'd0, stall_count}, 32'd30);
      step("to_rst", 1, 0, 0, 0, 0, 0, RSTV, 2'd0);
      check("timeout_clr", {31'd0, mem_timeout}, 32'd0);
      check("cnt_clr", {16'd0, stall_count}, 32'd0);

      step("abort_issue", 0, 0, 0, 1, 0, 0, MDUST, 2'd0);
      step("abort_w1", 0, 0, 0, 0, 0, 0, MDUST, 2'd2);
      step("abort_rst", 1, 0, 0, 0, 0, 0, RSTV, 2'd2);
      step("abort_idle", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      step("abort_idle2", 0, 0, 0, 0, 0, 0, DEF, 2'd0);
      check("cnt_abort", {16'd0, stall_count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Arbitrates four requesters competing for the pipeline-register write enables and flushes:
  - data-memory wait (MEM stage)
  - fixed-latency multiply/divide unit (EX stage)
  - taken-branch redirect (EX stage)
  - load-use hazard (ID stage)
- Drives the PC and IF/ID, ID/EX and EX/MEM enables and flushes, tracks multi-cycle stalls with a small FSM, and keeps a stall performance counter.

Parameters:
- MDU_LATENCY, 4, total EX-stage cycles of an MDU op (>=2); the stall lasts MDU_LATENCY-1 cycles after issue.
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before mem_timeout is flagged.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_use_req  in  1  load-use hazard detected for the instruction in ID.
- branch_taken  in  1  branch/jump in EX resolved taken.
- mdu_start  in  1  MDU instruction in EX, first cycle.
- mem_req  in  1  load/store present in MEM stage.
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID enable.
- IDEXWrite  out  1  ID/EX enable.
- EXMEMWrite  out  1  EX/MEM enable.
- IFIDFlush  out  1  load NOP into IF/ID.
- IDEXFlush  out  1  load NOP (zero control) into ID/EX.
- EXMEMFlush  out  1  load NOP into EX/MEM.
- mem_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  saturating count of cycles with PCWrite=0.
- state_o  out  2  current FSM state (IDLE=0, MEM_WAIT=1, MDU_WAIT=2).

Behaviour:
- All state is updated on the rising edge of clk; rst is sampled synchronously.
- Reset while rst=1:
  - All Write outputs are 0; IFIDFlush, IDEXFlush and EXMEMFlush are 1.
  - Next state is IDLE; mdu counter, mem-wait counter, stall_count and mem_timeout clear to 0.
  - Reset mid-stall aborts the stall with no residue.
- Outputs are combinational from state and request inputs. Default (no request): all Writes 1, all Flushes 0.
- IDLE decode, first match wins:
  1. mem_req && !mem_ready: all four Writes 0, no flush. Next state MEM_WAIT; mem-wait counter is set to 1.
  2. mdu_start: PCWrite, IFIDWrite and IDEXWrite are 0; EXMEMWrite=1 with EXMEMFlush=1 (bubble). Next state MDU_WAIT; mdu counter is set to MDU_LATENCY-2.
  3. branch_taken: PCWrite=1 (target loaded), IFIDFlush=1, IDEXFlush=1. Stay in IDLE; single-cycle flush.
  4. load_use_req: PCWrite=0, IFIDWrite=0, IDEXFlush=1. Stay in IDLE. The requester deasserts after the bubble moves forward, so the stall is one cycle per hazard.
- Masked lower-priority requests are not latched. Their sources stay frozen and re-present the request after release.
- MEM_WAIT:
  - While !mem_ready: all Writes 0. The mem-wait counter increments, saturating at MEM_TIMEOUT.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set. It is cleared only by rst, and the stall continues.
  - Cycle with mem_ready=1: apply the IDLE decode for items 2-4, with item 1 suppressed. Next state IDLE, or MDU_WAIT if mdu_start wins.
- MDU_WAIT:
  - While the counter is nonzero: PCWrite, IFIDWrite and IDEXWrite are 0, EXMEMFlush=1, and the counter decrements.
  - Cycle with counter == 0: normal IDLE decode; next state per that decode.
  - mem_req is guaranteed 0 in this state (EX/MEM holds bubbles). branch_taken, mdu_start and load_use_req are ignored while the counter is nonzero.
- mdu_start and branch_taken asserted together is illegal. Required handling: mdu_start wins, and the branch is re-presented after release.
- stall_count increments every non-reset cycle with PCWrite=0 and saturates at all-ones.
- Write/Flush conflicts: if a Flush is 1, the corresponding Write is treated as 1 by the register. The block never drives Flush=1 with Write=0 on the same register except during rst.

Test Plan:
- rst held 2 cycles, then released with no requests -> during rst all Writes 0 and all Flushes 1; afterwards all Writes 1, stall_count=0, state_o=0.
- load_use_req pulsed 1 cycle -> that cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle defaults; stall_count=1.
- mdu_start 1 cycle with MDU_LATENCY=4 -> 3 cycles with PCWrite=0 and EXMEMFlush=1 (issue cycle plus 2 in MDU_WAIT), release on the 4th cycle, stall_count=3.
- mem_req=1, mem_ready low for 3 cycles then high, with branch_taken=1 throughout -> 3 cycles with all Writes 0; on the ready cycle PCWrite=1, IFIDFlush=1, IDEXFlush=1; state returns to 0.
- mem_ready held low 20 cycles with MEM_TIMEOUT=16 -> mem_timeout rises once the counter reaches 16, stays 1 after mem_ready, and clears only on rst.
- rst asserted on the 2nd MDU_WAIT cycle -> state_o=0 next cycle, no further stall cycles, stall_count=0.
